// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IF-stage fetch sequencer with credit-limited imem requests, in-order response matching and a decode buffer
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_instr_o
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {RUN, DRAIN} state_t;
  state_t state, state_nxt;
  logic [31:0] pc;
  logic [31:0] pend_mem [DEPTH];
  logic [31:0] buf_pc [DEPTH];
  logic [31:0] buf_instr [DEPTH];
  logic [AW-1:0] pend_wr, pend_rd, buf_wr, buf_rd;
  logic [AW:0] pend_cnt, buf_cnt, kill_cnt, kill_nxt;
  logic [AW+1:0] used;
  logic accept, discard, push, pop, rsp_hit;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      kill_cnt <= '0;
    end else begin
      state    <= state_nxt;
      kill_cnt <= kill_nxt;
    end
  end
  // Beats still owed for requests killed by a redirect are absorbed before live ones
  always_comb begin
    kill_nxt  = redirect_valid_i ? kill_cnt + pend_cnt - (AW+1)'(rsp_hit) : kill_cnt - (AW+1)'(discard);
    state_nxt = (kill_nxt != '0) ? DRAIN : RUN;
  end
  always_comb begin
    used             = (AW+2)'(pend_cnt) + (AW+2)'(kill_cnt) + (AW+2)'(buf_cnt);
    imem_req_valid_o = rst & fetch_en_i & ~redirect_valid_i & (used < (AW+2)'(DEPTH));
    accept           = imem_req_valid_o & imem_req_ready_i;
    discard          = imem_rsp_valid_i & (state == DRAIN);
    push             = imem_rsp_valid_i & (state == RUN) & (pend_cnt != '0) & ~redirect_valid_i;
    rsp_hit          = imem_rsp_valid_i & ((pend_cnt != '0) | (kill_cnt != '0));
    id_valid_o       = (buf_cnt != '0) & ~redirect_valid_i;
    pop              = id_valid_o & id_ready_i;
  end
  assign imem_req_addr_o = pc;
  assign id_pc_o         = buf_pc[buf_rd];
  assign id_instr_o      = buf_instr[buf_rd];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc       <= RESET_PC;
      pend_wr  <= '0;
      pend_rd  <= '0;
      pend_cnt <= '0;
      buf_wr   <= '0;
      buf_rd   <= '0;
      buf_cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pend_mem[i]  <= '0;
        buf_pc[i]    <= '0;
        buf_instr[i] <= '0;
      end
    end else if (redirect_valid_i) begin
      pc       <= redirect_pc_i;
      pend_wr  <= '0;
      pend_rd  <= '0;
      pend_cnt <= '0;
      buf_wr   <= '0;
      buf_rd   <= '0;
      buf_cnt  <= '0;
    end else begin
      if (accept) begin
        pc                <= pc + 32'd4;
        pend_mem[pend_wr] <= pc;
        pend_wr           <= pend_wr + AW'(1);
      end
      if (push) begin
        pend_rd           <= pend_rd + AW'(1);
        buf_pc[buf_wr]    <= pend_mem[pend_rd];
        buf_instr[buf_wr] <= imem_rsp_data_i;
        buf_wr            <= buf_wr + AW'(1);
      end
      if (pop) buf_rd <= buf_rd + AW'(1);
      pend_cnt <= pend_cnt + (AW+1)'(accept) - (AW+1)'(push);
      buf_cnt  <= buf_cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scoreboard bench; an imem model answers with addr|0x13 after a set latency
module tb_fetch_ctrl;
  logic clk = 0, rst, fetch_en, redirect_valid, imem_req_ready, imem_rsp_valid, id_ready;
  logic [31:0] redirect_pc, imem_rsp_data;
  logic imem_req_valid, id_valid;
  logic [31:0] imem_req_addr, id_pc, id_instr;
  typedef struct packed {logic [31:0] pc; logic [31:0] instr;} exp_t;
  typedef struct packed {logic [31:0] addr; int due;} mem_t;
  exp_t exp_q[$];
  mem_t mq[$];
  exp_t e;
  mem_t m;
  int checks = 0, failures = 0, acc_cnt = 0, cyc = 0, lat = 1;

  fetch_ctrl #(.RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .fetch_en_i(fetch_en),
    .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
    .imem_req_valid_o(imem_req_valid), .imem_req_ready_i(imem_req_ready),
    .imem_req_addr_o(imem_req_addr), .imem_rsp_valid_i(imem_rsp_valid),
    .imem_rsp_data_i(imem_rsp_data), .id_valid_o(id_valid), .id_ready_i(id_ready),
    .id_pc_o(id_pc), .id_instr_o(id_instr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_id(logic [31:0] p, logic [31:0] i);
    exp_q.push_back('{p, i});
  endtask

  task automatic issue(int n);
    int t = acc_cnt + n;
    int b = 0;
    fetch_en = 1;
    while (acc_cnt < t && b < 100) begin
      step();
      b++;
    end
    fetch_en = 0;
    chk("issue_count", acc_cnt, t);
  endtask

  task automatic drain();
    int b = 0;
    while (exp_q.size() != 0 && b < 200) begin
      step();
      b++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 0;
    exp_q.delete();
    step();
    step();
    rst = 1;
  endtask

  // imem model: records accepts just before the edge, answers in order after lat cycles
  always @(negedge clk) begin
    if (!rst) mq.delete();
    else if (imem_req_valid && imem_req_ready) begin
      mq.push_back('{imem_req_addr, cyc + 1 + lat});
      acc_cnt++;
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (rst && mq.size() != 0 && mq[0].due <= cyc + 1) begin
      m = mq.pop_front();
      imem_rsp_valid = 1;
      imem_rsp_data  = m.addr | 32'h13;
    end else begin
      imem_rsp_valid = 0;
      imem_rsp_data  = 0;
    end
  end

  // scoreboard monitor: compares every decode handshake against the next expected entry
  always @(negedge clk) begin
    if (rst && id_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_id actual_pc=%h expected=none", id_pc);
      end else begin
        e = exp_q.pop_front();
        chk("id_pc", id_pc, e.pc);
        chk("id_instr", id_instr, e.instr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    int a, n, b;
    rst = 0; fetch_en = 1; redirect_valid = 0; redirect_pc = 0;
    imem_req_ready = 1; id_ready = 1; imem_rsp_valid = 0; imem_rsp_data = 0;
    step();
    step();
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_id_valid", id_valid, 0);
    chk("rst_id_pc", id_pc, 0);
    chk("rst_id_instr", id_instr, 0);
    chk("rst_addr", imem_req_addr, 0);
    // 1: streaming from reset, with memory stalling first
    imem_req_ready = 0;
    rst = 1;
    a = acc_cnt;
    repeat (3) step();
    chk("noready_valid", imem_req_valid, 1);
    chk("noready_acc", acc_cnt - a, 0);
    imem_req_ready = 1;
    expect_id(32'h0, 32'h13);
    expect_id(32'h4, 32'h17);
    expect_id(32'h8, 32'h1b);
    expect_id(32'hC, 32'h1f);
    issue(4);
    drain();
    // 2: decode backpressure limits issue to the credit depth
    fetch_en = 0;
    do_reset();
    id_ready = 0;
    fetch_en = 1;
    a = acc_cnt;
    repeat (6) step();
    chk("hold_acc", acc_cnt - a, 2);
    chk("hold_req_valid", imem_req_valid, 0);
    chk("hold_id_valid", id_valid, 1);
    expect_id(32'h0, 32'h13);
    expect_id(32'h4, 32'h17);
    expect_id(32'h8, 32'h1b);
    id_ready = 1;
    issue(1);
    drain();
    // 3: redirect with two requests in flight (0xC, 0x10) at latency 3
    lat = 3;
    issue(2);
    fetch_en = 1;
    redirect_valid = 1;
    redirect_pc = 32'h100;
    #1;
    chk("redir3_req_valid", imem_req_valid, 0);
    chk("redir3_id_valid", id_valid, 0);
    step();
    redirect_valid = 0;
    fetch_en = 0;
    expect_id(32'h100, 32'h113);
    issue(1);
    drain();
    // 4: redirect coincides with a response beat while the buffer holds 0x104
    lat = 2;
    id_ready = 0;
    issue(2);
    n = 0;
    b = 0;
    while (b < 20) begin
      if (imem_rsp_valid) n++;
      if (n == 2) break;
      step();
      b++;
    end
    chk("rsp_seen", n, 2);
    chk("pre_redir_id_valid", id_valid, 1);
    redirect_valid = 1;
    redirect_pc = 32'h200;
    #1;
    chk("redir4_id_valid", id_valid, 0);
    step();
    redirect_valid = 0;
    id_ready = 1;
    expect_id(32'h200, 32'h213);
    issue(1);
    drain();
    id_ready = 0;
    a = acc_cnt;
    fetch_en = 1;
    repeat (8) step();
    fetch_en = 0;
    chk("kill_clear_acc", acc_cnt - a, 2);
    chk("kill_clear_id_valid", id_valid, 1);
    // 5: async reset with one buffered instruction and credit available
    expect_id(32'h204, 32'h217);
    id_ready = 1;
    step();
    id_ready = 0;
    fetch_en = 1;
    #1;
    chk("pre_rst_req_valid", imem_req_valid, 1);
    chk("pre_rst_id_valid", id_valid, 1);
    rst = 0;
    #1;
    chk("async_rst_req_valid", imem_req_valid, 0);
    chk("async_rst_id_valid", id_valid, 0);
    chk("async_rst_id_pc", id_pc, 0);
    exp_q.delete();
    step();
    rst = 1;
    #1;
    chk("post_rst_addr", imem_req_addr, 0);
    chk("post_rst_req_valid", imem_req_valid, 1);
    id_ready = 1;
    expect_id(32'h0, 32'h13);
    issue(1);
    drain();
    // 6: fetch disabled with two outstanding, then PC wrap
    lat = 3;
    expect_id(32'h4, 32'h17);
    expect_id(32'h8, 32'h1b);
    issue(2);
    a = acc_cnt;
    repeat (8) step();
    chk("noen_acc", acc_cnt - a, 0);
    drain();
    step();
    chk("noen_id_valid", id_valid, 0);
    redirect_valid = 1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 0;
    chk("wrap_addr0", imem_req_addr, 32'hFFFF_FFFC);
    expect_id(32'hFFFF_FFFC, 32'hFFFF_FFFF);
    expect_id(32'h0, 32'h13);
    issue(1);
    chk("wrap_addr1", imem_req_addr, 32'h0);
    issue(1);
    drain();
    step();
    chk("end_id_valid", id_valid, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
